pc_branch_unit: RTL and testbench

Parametrised program-counter unit for the pipelined core: holds the fetch PC, predicts the next fetch address from a direct-mapped branch target buffer with 2-bit saturating counters, and redirects on misprediction. It sits between fetch and the branch-resolution stage. It generalises the combinational branch/halt next-PC logic to configurable widths and depth, and adds registered state, stall, sticky halt, prediction and flush.

---
 rtl/pc_branch_pkg.sv | 40 ++++
 rtl/branch_cond_eval.sv | 36 +++
 rtl/pc_branch_unit.sv | 135 +++++++++++++
 tb/tb_pc_branch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_pkg.sv
// Shared constants and helpers for the PC / branch prediction unit.
// Condition codes, 2-bit counter states and the condition evaluator.
package pc_branch_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OVF = 3'b110;
    localparam logic [2:0] COND_AL  = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // flags are packed {V,N,Z}
    function automatic logic cond_met(
        input logic [2:0] cond,
        input logic [2:0] flags
    );
        logic v, n, z;
        v = flags[2];
        n = flags[1];
        z = flags[0];
        case (cond)
            COND_NE:  cond_met = ~z;
            COND_EQ:  cond_met = z;
            COND_GT:  cond_met = ~n & ~z;
            COND_LT:  cond_met = n;
            COND_GE:  cond_met = ~n | z;
            COND_LE:  cond_met = n | z;
            COND_OVF: cond_met = v;
            default:  cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution: condition check, target, correct next PC.
// In: branch kind, pc, cond, flags, imm, reg target. Out: taken, target, next.
module branch_cond_eval
    import pc_branch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 9
) (
    input  logic              i_is_branch,
    input  logic              i_is_reg,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [2:0]        i_cond,
    input  logic [2:0]        i_flags,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [ADDR_W-1:0] i_reg_target,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target,
    output logic [ADDR_W-1:0] o_correct_next
);

    localparam int EXT_W = ADDR_W - IMM_W;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_sext;
    logic [ADDR_W-1:0] w_off;

    assign w_seq  = i_pc + ADDR_W'(2);
    assign w_sext = {{EXT_W{i_imm[IMM_W-1]}}, i_imm};
    // immediate is a word offset; bytes = offset * 2, top bit drops on wrap
    assign w_off  = {w_sext[ADDR_W-2:0], 1'b0};

    assign o_taken        = i_is_branch & cond_met(i_cond, i_flags);
    assign o_target       = i_is_reg ? i_reg_target : (w_seq + w_off);
    assign o_correct_next = o_taken ? o_target : w_seq;

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with direct-mapped BTB prediction and flush redirect.
// Fetch side: stall/halt_fetch -> pc_out/pred_*; resolve side: res_* -> flush.
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              IMM_W     = 9,
    parameter int              BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt_fetch,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pred_next,
    output logic              pred_taken,
    output logic              halted,
    input  logic              res_valid,
    input  logic              res_is_branch,
    input  logic              res_is_reg,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [2:0]        res_cond,
    input  logic [2:0]        res_flags,
    input  logic [IMM_W-1:0]  res_imm,
    input  logic [ADDR_W-1:0] res_reg_target,
    input  logic [ADDR_W-1:0] res_pred_next,
    output logic              flush
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    logic              r_btb_valid [BTB_DEPTH];
    logic [TAG_W-1:0]  r_btb_tag   [BTB_DEPTH];
    logic [ADDR_W-1:0] r_btb_tgt   [BTB_DEPTH];
    logic [1:0]        r_btb_ctr   [BTB_DEPTH];

    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;

    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_correct;

    logic [IDX_W-1:0]  w_fidx;
    logic [TAG_W-1:0]  w_ftag;
    logic              w_fhit;
    logic [IDX_W-1:0]  w_ridx;
    logic [TAG_W-1:0]  w_rtag;
    logic              w_rhit;
    logic              w_upd;
    logic [ADDR_W-1:0] w_npc;

    branch_cond_eval #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_eval (
        .i_is_branch    (res_is_branch),
        .i_is_reg       (res_is_reg),
        .i_pc           (res_pc),
        .i_cond         (res_cond),
        .i_flags        (res_flags),
        .i_imm          (res_imm),
        .i_reg_target   (res_reg_target),
        .o_taken        (w_taken),
        .o_target       (w_target),
        .o_correct_next (w_correct)
    );

    // fetch-side lookup
    assign w_fidx     = r_pc[IDX_W:1];
    assign w_ftag     = r_pc[ADDR_W-1:IDX_W+1];
    assign w_fhit     = r_btb_valid[w_fidx] & (r_btb_tag[w_fidx] == w_ftag);
    assign pred_taken = w_fhit & r_btb_ctr[w_fidx][1];
    assign pred_next  = pred_taken ? r_btb_tgt[w_fidx] : r_pc + ADDR_W'(2);

    // resolve-side lookup
    assign w_ridx = res_pc[IDX_W:1];
    assign w_rtag = res_pc[ADDR_W-1:IDX_W+1];
    assign w_rhit = r_btb_valid[w_ridx] & (r_btb_tag[w_ridx] == w_rtag);
    assign w_upd  = res_valid & res_is_branch;

    assign flush  = res_valid & (res_pred_next != w_correct);
    assign pc_out = r_pc;
    assign halted = r_halted;

    always_comb begin
        w_npc = pred_next;
        if (flush)
            w_npc = w_correct;
        else if (r_halted | halt_fetch | stall)
            w_npc = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_pc <= w_npc;
            if (flush)
                r_halted <= 1'b0;
            else if (halt_fetch & ~stall)
                r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_tgt[i]   <= '0;
                r_btb_ctr[i]   <= CTR_WNT;
            end
        end else if (w_upd) begin
            if (w_taken) begin
                if (w_rhit) begin
                    if (r_btb_ctr[w_ridx] != CTR_ST)
                        r_btb_ctr[w_ridx] <= r_btb_ctr[w_ridx] + 2'd1;
                    r_btb_tgt[w_ridx] <= w_target;
                end else begin
                    r_btb_valid[w_ridx] <= 1'b1;
                    r_btb_tag[w_ridx]   <= w_rtag;
                    r_btb_tgt[w_ridx]   <= w_target;
                    r_btb_ctr[w_ridx]   <= CTR_WT;
                end
            end else if (w_rhit && r_btb_ctr[w_ridx] != CTR_SNT) begin
                r_btb_ctr[w_ridx] <= r_btb_ctr[w_ridx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit.
// Drives fetch and resolution ports, compares against hand-computed values.
module tb_pc_branch_unit;

    localparam int ADDR_W = 16;
    localparam int IMM_W  = 9;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              halt_fetch;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pred_next;
    logic              pred_taken;
    logic              halted;
    logic              res_valid;
    logic              res_is_branch;
    logic              res_is_reg;
    logic [ADDR_W-1:0] res_pc;
    logic [2:0]        res_cond;
    logic [2:0]        res_flags;
    logic [IMM_W-1:0]  res_imm;
    logic [ADDR_W-1:0] res_reg_target;
    logic [ADDR_W-1:0] res_pred_next;
    logic              flush;

    int n_chk;
    int n_fail;

    pc_branch_unit #(
        .ADDR_W    (ADDR_W),
        .IMM_W     (IMM_W),
        .BTB_DEPTH (16),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt_fetch     (halt_fetch),
        .pc_out         (pc_out),
        .pred_next      (pred_next),
        .pred_taken     (pred_taken),
        .halted         (halted),
        .res_valid      (res_valid),
        .res_is_branch  (res_is_branch),
        .res_is_reg     (res_is_reg),
        .res_pc         (res_pc),
        .res_cond       (res_cond),
        .res_flags      (res_flags),
        .res_imm        (res_imm),
        .res_reg_target (res_reg_target),
        .res_pred_next  (res_pred_next),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // force the fetch PC to a via a non-branch misprediction
    task automatic redirect(input logic [ADDR_W-1:0] a);
        res_valid     = 1'b1;
        res_is_branch = 1'b0;
        res_is_reg    = 1'b0;
        res_pc        = a - 16'd2;
        res_pred_next = ~a;
        tick();
        res_valid = 1'b0;
        #1;
    endtask

    task automatic resolve_b(input logic [ADDR_W-1:0] pc,
                             input logic [2:0] cond,
                             input logic [2:0] flags,
                             input logic [IMM_W-1:0] imm,
                             input logic [ADDR_W-1:0] pn);
        res_valid     = 1'b1;
        res_is_branch = 1'b1;
        res_is_reg    = 1'b0;
        res_pc        = pc;
        res_cond      = cond;
        res_flags     = flags;
        res_imm       = imm;
        res_pred_next = pn;
        #1;
    endtask

    typedef struct {
        logic [2:0] c;
        logic [2:0] f;
        logic       t;
    } vec_t;

    vec_t tbl[10];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl[0] = '{3'b000, 3'b000, 1'b1};
        tbl[1] = '{3'b001, 3'b000, 1'b0};
        tbl[2] = '{3'b010, 3'b000, 1'b1};
        tbl[3] = '{3'b010, 3'b001, 1'b0};
        tbl[4] = '{3'b011, 3'b010, 1'b1};
        tbl[5] = '{3'b100, 3'b010, 1'b0};
        tbl[6] = '{3'b100, 3'b011, 1'b1};
        tbl[7] = '{3'b101, 3'b000, 1'b0};
        tbl[8] = '{3'b110, 3'b100, 1'b1};
        tbl[9] = '{3'b111, 3'b000, 1'b1};

        rst_n          = 1'b0;
        stall          = 1'b0;
        halt_fetch     = 1'b0;
        res_valid      = 1'b0;
        res_is_branch  = 1'b0;
        res_is_reg     = 1'b0;
        res_pc         = '0;
        res_cond       = '0;
        res_flags      = '0;
        res_imm        = '0;
        res_reg_target = '0;
        res_pred_next  = '0;
        #12;
        chk("rst_pc", 32'(pc_out), 32'h0000);
        chk("rst_pred_next", 32'(pred_next), 32'h0002);
        chk("rst_pred_taken", 32'(pred_taken), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_flush", 32'(flush), 0);
        rst_n = 1'b1;
        #1;

        // free running
        chk("run0", 32'(pc_out), 32'h0000);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("run%0d", i), 32'(pc_out), 32'(2 * i));
            chk($sformatf("run%0d_pt", i), 32'(pred_taken), 0);
        end

        // condition codes: flush == taken when predicted fall-through
        foreach (tbl[i]) begin
            resolve_b(16'h0200, tbl[i].c, tbl[i].f, 9'h004, 16'h0202);
            chk($sformatf("cond%0d", i), 32'(flush), 32'(tbl[i].t));
            res_valid = 1'b0;
            tick();
        end

        // negative immediate: 0x100+2-16 = 0xF2
        resolve_b(16'h0100, 3'b111, 3'b000, 9'h1F8, 16'h0102);
        chk("neg_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("neg_pc", 32'(pc_out), 32'h00F2);

        // target wrap: 0xFFF0+2+16 = 0x0002
        resolve_b(16'hFFF0, 3'b111, 3'b000, 9'h008, 16'h0000);
        chk("wrap_tgt_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("wrap_tgt_pc", 32'(pc_out), 32'h0002);

        // sequential wrap
        redirect(16'hFFFE);
        chk("wrap_seq_pn", 32'(pred_next), 32'h0000);
        tick();
        chk("wrap_seq_pc", 32'(pc_out), 32'h0000);

        // B always taken at 0x10, allocated
        resolve_b(16'h0010, 3'b111, 3'b000, 9'h004, 16'h0012);
        chk("b_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("b_pc", 32'(pc_out), 32'h001A);
        redirect(16'h0010);
        chk("b_pred_taken", 32'(pred_taken), 1);
        chk("b_pred_next", 32'(pred_next), 32'h001A);

        // two not-taken resolutions: 10 -> 01 -> 00
        resolve_b(16'h0010, 3'b000, 3'b001, 9'h004, 16'h0012);
        chk("nt1_flush", 32'(flush), 0);
        tick();
        resolve_b(16'h0010, 3'b000, 3'b001, 9'h004, 16'h001A);
        chk("nt2_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("nt2_pc", 32'(pc_out), 32'h0012);
        redirect(16'h0010);
        chk("nt_pred_taken", 32'(pred_taken), 0);
        chk("nt_pred_next", 32'(pred_next), 32'h0012);

        // BR EQ with Z=1, correctly predicted; counter 00 -> 01 -> 10
        for (int k = 0; k < 2; k++) begin
            res_valid      = 1'b1;
            res_is_branch  = 1'b1;
            res_is_reg     = 1'b1;
            res_pc         = 16'h0010;
            res_cond       = 3'b001;
            res_flags      = 3'b001;
            res_reg_target = 16'h1234;
            res_pred_next  = 16'h1234;
            #1;
            chk($sformatf("br%0d_flush", k), 32'(flush), 0);
            tick();
            res_valid  = 1'b0;
            res_is_reg = 1'b0;
            redirect(16'h0010);
            chk($sformatf("br%0d_pt", k), 32'(pred_taken), 32'(k));
        end
        chk("br_pred_next", 32'(pred_next), 32'h1234);

        // sticky halt
        redirect(16'h0040);
        halt_fetch = 1'b1;
        tick();
        halt_fetch = 1'b0;
        #1;
        chk("halt_pc", 32'(pc_out), 32'h0040);
        chk("halt_flag", 32'(halted), 1);
        tick();
        chk("halt_hold_pc", 32'(pc_out), 32'h0040);
        chk("halt_hold_flag", 32'(halted), 1);
        res_valid     = 1'b1;
        res_is_branch = 1'b0;
        res_pc        = 16'h002E;
        res_pred_next = 16'h0000;
        #1;
        chk("halt_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("unhalt_pc", 32'(pc_out), 32'h0030);
        chk("unhalt_flag", 32'(halted), 0);

        // stall, then flush during stall
        stall = 1'b1;
        tick();
        chk("stall1", 32'(pc_out), 32'h0030);
        tick();
        chk("stall2", 32'(pc_out), 32'h0030);
        res_valid     = 1'b1;
        res_is_branch = 1'b0;
        res_pc        = 16'h007E;
        res_pred_next = 16'h0000;
        #1;
        chk("stall_flush", 32'(flush), 1);
        tick();
        res_valid = 1'b0;
        #1;
        chk("stall_flush_pc", 32'(pc_out), 32'h0080);
        halt_fetch = 1'b1;
        tick();
        chk("stall_no_halt", 32'(halted), 0);
        chk("stall_hold", 32'(pc_out), 32'h0080);
        halt_fetch = 1'b0;
        stall      = 1'b0;

        // async reset mid-run
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc_out), 32'h0000);
        chk("arst_pn", 32'(pred_next), 32'h0002);
        tick();
        rst_n = 1'b1;
        #1;
        redirect(16'h0010);
        chk("arst_btb_pt", 32'(pred_taken), 0);
        chk("arst_btb_pn", 32'(pred_next), 32'h0012);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
